// File: rtl/fetch_bundle_queue.sv
// fetch_bundle_queue: decode-side receiver for 4-wide fetch bundles.
// Circular buffer of DEPTH bundles with a valid/ready handshake to decode,
// registered back-pressure to fetch, and a mispredict flush.
module fetch_bundle_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fetch_valid,
  input  logic [63:0]      pc_from_fetch,
  input  logic [63:0]      inst_from_fetch,
  input  logic [63:0]      recv_pc_from_fetch,
  input  logic [3:0]       pred_result_from_fetch,
  input  logic             has_mispredict,
  input  logic             dec_ready,
  output logic             stall_fetch,
  output logic             dec_valid,
  output logic [63:0]      pc_to_dec,
  output logic [63:0]      inst_to_dec,
  output logic [63:0]      recv_pc_to_dec,
  output logic [3:0]       pred_result_to_dec,
  output logic [PTR_W:0]   occupancy,
  output logic             overflow
);

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] inst;
    logic [63:0] rpc;
    logic [3:0]  pred;
  } bundle_t;

  localparam logic [PTR_W:0] FULL_CNT  = (PTR_W+1)'(DEPTH);
  // One slot of margin for the bundle already in flight from fetch.
  localparam logic [PTR_W:0] STALL_CNT = (PTR_W+1)'(DEPTH - 1);

  bundle_t              mem_q [DEPTH];
  bundle_t              head_ent;
  logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]       occ_q, occ_d;
  logic                 ovf_q, ovf_d;
  logic                 full, pop, push;

  assign full      = (occ_q == FULL_CNT);
  assign dec_valid = (occ_q != '0);
  assign pop       = dec_valid & dec_ready;
  // A pop frees a slot in the same cycle, so a full queue still accepts.
  assign push      = fetch_valid & ~has_mispredict & (~full | pop);

  // Next-state for pointers, count and sticky overflow; flush wins over all.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    ovf_d  = ovf_q | (fetch_valid & ~has_mispredict & full & ~pop);
    if (has_mispredict) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      if (pop)  head_d = head_q + 1'b1;
      if (push) tail_d = tail_q + 1'b1;
      if (push & ~pop)      occ_d = occ_q + 1'b1;
      else if (pop & ~push) occ_d = occ_q - 1'b1;
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      ovf_q  <= ovf_d;
    end
  end

  // Bundle storage is not reset; validity is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= '{pc:   pc_from_fetch,
                                 inst: inst_from_fetch,
                                 rpc:  recv_pc_from_fetch,
                                 pred: pred_result_from_fetch};
  end

  // Head entry presented combinationally, zeroed while empty.
  always_comb begin
    head_ent = dec_valid ? mem_q[head_q] : '0;
  end

  assign pc_to_dec          = head_ent.pc;
  assign inst_to_dec        = head_ent.inst;
  assign recv_pc_to_dec     = head_ent.rpc;
  assign pred_result_to_dec = head_ent.pred;
  assign occupancy          = occ_q;
  assign overflow           = ovf_q;
  assign stall_fetch        = (occ_q >= STALL_CNT);

endmodule

// File: doc/fetch_bundle_queue.md
Name: fetch_bundle_queue

Overview:
Decode-side receiver for the 4-wide fetch bundle interface. It captures packed bundles from fetch into a circular buffer of bundles and presents them to decode under a valid/ready handshake. It generates the stall_fetch back-pressure signal to fetch. On has_mispredict it flushes all buffered wrong-path bundles.

Parameters:
DEPTH, 4, number of bundle entries; must be a power of two, minimum 2.
PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
fetch_valid  input  1  fetch presents a bundle this cycle
pc_from_fetch  input  64  four 16-bit PCs; slot0 in [63:48], slot3 in [15:0]
inst_from_fetch  input  64  four 16-bit instructions, same slot packing
recv_pc_from_fetch  input  64  four 16-bit recovery PCs, same slot packing
pred_result_from_fetch  input  4  per-slot prediction bits; bit3 = slot0
has_mispredict  input  1  from ROB; flush request
dec_ready  input  1  decode consumes the head bundle this cycle
stall_fetch  output  1  back-pressure to fetch
dec_valid  output  1  head bundle valid
pc_to_dec  output  64  head bundle PCs
inst_to_dec  output  64  head bundle instructions
recv_pc_to_dec  output  64  head bundle recovery PCs
pred_result_to_dec  output  4  head bundle prediction bits
occupancy  output  PTR_W+1  number of bundles held
overflow  output  1  sticky error flag: a bundle was dropped because the queue was full

Behaviour:
- Reset is asynchronous and active-low. The clock port is clk and the reset port is rst_n.
- Reset values: head and tail pointers 0, occupancy 0, overflow 0, dec_valid 0, stall_fetch 0, all data outputs 0.
- Storage is DEPTH entries, each 196 bits (64 + 64 + 64 + 4). It is written at the tail and read at the head. Pointers wrap modulo DEPTH.
- pop = dec_valid & dec_ready.
- push = fetch_valid & ~has_mispredict & ((occupancy < DEPTH) | pop).
- Entry data is not reset; only the pointers and flags are.
- dec_valid = (occupancy != 0).
- Data outputs are driven combinationally from the head entry when dec_valid is 1, and are forced to 0 when the queue is empty.
- Latency: a bundle pushed in cycle N is visible on the outputs in cycle N+1. There is no same-cycle bypass.
- Push and pop in the same cycle: both take effect and occupancy is unchanged. This is allowed even when the queue is full.
- stall_fetch = (occupancy >= DEPTH-1). It depends on registered state only, with no combinational path from any input.
  - The threshold leaves one slot of margin for the bundle already in flight from fetch.
- Overflow: if fetch_valid & ~has_mispredict & (occupancy == DEPTH) & ~pop, the bundle is dropped and overflow is set. overflow clears only on reset.
- Flush: when has_mispredict is 1 in cycle N:
  - at the cycle N edge, head, tail and occupancy all go to 0;
  - the incoming bundle in cycle N is discarded;
  - a pop in cycle N has no further effect;
  - in cycle N+1, dec_valid = 0 and stall_fetch = 0.
- has_mispredict held high for several cycles keeps the queue empty throughout.
- occupancy width PTR_W+1 represents 0..DEPTH inclusive. The full and empty states are distinguished by the count, not by pointer equality.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge.

Test Plan:
- Reset, then push one bundle with PCs 0x0000/0x0001/0x0002/0x0003 and pred=4'b0100, dec_ready=0 -> cycle+1: dec_valid=1, pc_to_dec=64'h0000_0001_0002_0003, pred_result_to_dec=4'b0100, occupancy=1.
- DEPTH=4, dec_ready=0, push bundles on 3 consecutive cycles -> occupancy=3 and stall_fetch=1 in the cycle after the 3rd push. A 4th push is accepted (occupancy=4). A 5th push sets overflow=1 and occupancy stays 4.
- Full queue (4 entries), fetch_valid=1 and dec_ready=1 together -> occupancy stays 4, head advances, new bundle written at the wrapped tail. Draining then returns the bundles in FIFO order.
- Queue holding 3 bundles, has_mispredict=1 together with fetch_valid=1 and dec_ready=1 -> next cycle: occupancy=0, dec_valid=0, stall_fetch=0, all data outputs 0.
- Continuous push and pop for 10 cycles with incrementing PCs -> occupancy constant at 1 and the output sequence matches the input sequence exactly across pointer wrap.
- rst_n pulsed low asynchronously with occupancy=2 -> occupancy=0 and dec_valid=0 before the next clock edge, and overflow is cleared.
